// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake. The frame is a start bit,
// 8 data bits sent LSB first, an optional parity bit and 1 or 2 stop bits.
module uart_tx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int          DIV    = CLOCK_FREQ / BAUD;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("uart_tx: CLOCK_FREQ/BAUD must be in 2..65535");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e      state_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shreg_q;
  logic        par_q;
  logic        tx_q;
  logic        ready_q;
  logic        busy_q;

  // NOTE: every register here is assigned with <= so all branches see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else if (state_q == S_IDLE) begin
      ready_q <= 1'b1;
      if (tx_valid && ready_q) begin
        shreg_q    <= tx_data;
        par_q      <= (PARITY == 2) ? ^tx_data : ~^tx_data;
        state_q    <= S_START;
        tx_q       <= 1'b0;
        busy_q     <= 1'b1;
        ready_q    <= 1'b0;
        baud_cnt_q <= DIV_M1;
        bit_cnt_q  <= '0;
      end
    end else if (baud_cnt_q != 16'd0) begin
      baud_cnt_q <= baud_cnt_q - 16'd1;
    end else begin
      // End of the current line bit: pick the next bit and restart its period.
      baud_cnt_q <= DIV_M1;
      case (state_q)
        S_START: begin
          state_q <= S_DATA;
          tx_q    <= shreg_q[0];
          shreg_q <= {1'b0, shreg_q[7:1]};
        end
        S_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_q <= '0;
            if (PARITY != 0) begin
              state_q <= S_PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            tx_q      <= shreg_q[0];
            shreg_q   <= {1'b0, shreg_q[7:1]};
          end
        end
        S_PARITY: begin
          state_q   <= S_STOP;
          tx_q      <= 1'b1;
          bit_cnt_q <= '0;
        end
        S_STOP: begin
          // bit_cnt_q counts stop-bit periods here.
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10: three instances cover no parity/1 stop,
// even parity/2 stop and odd parity/1 stop.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] valid_v = 3'b000;
  logic [2:0] ready_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLOCK_FREQ(1000000), .BAUD(100000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0])
  );
  uart_tx #(.CLOCK_FREQ(1000000), .BAUD(100000), .PARITY(2), .STOP_BITS(2)) u_dut_even (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1])
  );
  uart_tx #(.CLOCK_FREQ(1000000), .BAUD(100000), .PARITY(1), .STOP_BITS(1)) u_dut_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2])
  );

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic do_accept(input int s, input logic [7:0] d, output bit ok);
    tx_data    = d;
    valid_v[s] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready_v[s] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: dut=%0d tx_ready never went 1 (want 1)", s);
      valid_v[s] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    valid_v[s] = 1'b0;
  endtask

  // Walks a whole frame clock by clock starting at k=0 (negedge after accept).
  task automatic check_frame(input string name, input int s, input logic [7:0] d,
                             input int npar, input logic pbit, input int stops,
                             input bit disturb);
    int   n;
    int   b;
    logic exp;
    n = 9 + npar + stops;
    for (int k = 0; k < n * 10; k++) begin
      b = k / 10;
      if (b == 0)                  exp = 1'b0;
      else if (b <= 8)             exp = d[b-1];
      else if (npar != 0 && b == 9) exp = pbit;
      else                         exp = 1'b1;
      total += 2;
      if (tx_v[s] !== exp) begin
        bad++;
        $display("FAIL %s_tx: k=%0d got %b want %b", name, k, tx_v[s], exp);
      end
      if (busy_v[s] !== 1'b1 || ready_v[s] !== 1'b0) begin
        bad++;
        $display("FAIL %s_busy: k=%0d busy=%b ready=%b want busy=1 ready=0",
                 name, k, busy_v[s], ready_v[s]);
      end
      if (disturb) begin
        if (k == 30) tx_data = 8'h3C;
        if (k == 40) valid_v[s] = 1'b1;
        if (k == 41) valid_v[s] = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if ({tx_v[s], busy_v[s], ready_v[s]} !== 3'b101) begin
      bad++;
      $display("FAIL %s_end: tx/busy/ready got %b want 101", name,
               {tx_v[s], busy_v[s], ready_v[s]});
    end
  endtask

  // Independent line decoder: finds the start bit and samples mid-bit.
  task automatic rx_byte(input int s, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (tx_v[s] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    repeat (5) @(negedge clk);
    if (tx_v[s] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      d[i] = tx_v[s];
    end
    repeat (10) @(negedge clk);
    if (tx_v[s] !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({tx_v, busy_v, ready_v} !== 9'b111_000_000) begin
        bad++;
        $display("FAIL reset_hold: tx=%b busy=%b ready=%b want tx=111 busy=000 ready=000",
                 tx_v, busy_v, ready_v);
      end
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({tx_v, busy_v, ready_v} !== 9'b111_000_111) begin
        bad++;
        $display("FAIL reset_idle: tx=%b busy=%b ready=%b want tx=111 busy=000 ready=111",
                 tx_v, busy_v, ready_v);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    do_accept(0, 8'hA5, ok);
    if (ok) check_frame("a5", 0, 8'hA5, 0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit         ok;
    logic [7:0] d;
    int         t1;
    int         t2;
    bit         found;
    t1 = 0;
    t2 = 0;
    tx_data    = 8'h00;
    valid_v[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready_v[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    t1 = cyc;
    @(negedge clk);
    tx_data = 8'hFF;
    rx_byte(0, d, ok);
    total++;
    if (!found || !ok || d !== 8'h00) begin
      bad++;
      $display("FAIL b2b_first: got %h ok=%0d want 00 ok=1", d, ok);
    end
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready_v[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    t2 = cyc;
    total++;
    if (!found || (t2 - t1) !== 101) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d clks want 101", t2 - t1);
    end
    @(negedge clk);
    valid_v[0] = 1'b0;
    rx_byte(0, d, ok);
    total++;
    if (!ok || d !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_second: got %h ok=%0d want ff ok=1", d, ok);
    end
  endtask

  task automatic test_data_stability();
    bit ok;
    do_accept(0, 8'h81, ok);
    if (ok) check_frame("stab", 0, 8'h81, 0, 1'b0, 1, 1'b1);
    repeat (20) begin
      @(negedge clk);
      total++;
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
        bad++;
        $display("FAIL stab_no_frame: tx=%b busy=%b want tx=1 busy=0", tx_v[0], busy_v[0]);
      end
    end
  endtask

  task automatic test_parity();
    bit ok;
    do_accept(1, 8'h07, ok);
    if (ok) check_frame("even", 1, 8'h07, 1, 1'b1, 2, 1'b0);
    do_accept(2, 8'h07, ok);
    if (ok) check_frame("odd", 2, 8'h07, 1, 1'b0, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_accept(0, 8'h55, ok);
    repeat (43) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({tx_v[0], busy_v[0], ready_v[0]} !== 3'b100) begin
      bad++;
      $display("FAIL midrst_abort: tx/busy/ready got %b want 100",
               {tx_v[0], busy_v[0], ready_v[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({tx_v[0], busy_v[0], ready_v[0]} !== 3'b101) begin
      bad++;
      $display("FAIL midrst_idle: tx/busy/ready got %b want 101",
               {tx_v[0], busy_v[0], ready_v[0]});
    end
    do_accept(0, 8'h12, ok);
    if (ok) check_frame("after_rst", 0, 8'h12, 0, 1'b0, 1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_data_stability();
    test_parity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
